rxiod_clkdiv_delay_ctrl: RTL and testbench

//  Fabric-side initiator for the RX clock-divider delay-line control pins (DIR/MOVE/LOAD/BIT_SLIP).

---
 rtl/rxiod_dly_pkg.sv | 26 ++
 rtl/rxiod_dly_sync.sv | 21 ++
 rtl/rxiod_clkdiv_delay_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rxiod_clkdiv_delay_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rxiod_dly_pkg.sv
// Shared encodings for the RX clock-divider delay-line controller: command
// opcodes, FSM states and the settle-counter sizing helper.
package rxiod_dly_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_SLIP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PULSE  = 2'd1,
    S_SETTLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  // Counter holds SETTLE_CYC-1 down to 0; never narrower than one bit.
  function automatic int settle_cnt_w(input int settle_cyc);
    int w;
    w = $clog2(settle_cyc);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rxiod_dly_sync.sv
// Two-flop synchroniser for the delay line's out-of-range status flag.
module rxiod_dly_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rxiod_clkdiv_delay_ctrl.sv
// Issues spaced DIR/MOVE/LOAD/BIT_SLIP pulses to the RXIOD delay line and tracks the tap.
// Define RXIOD_DLY_OOR_SYNC_EN to pass the out-of-range flag through a 2-flop synchroniser.
module rxiod_clkdiv_delay_ctrl
  import rxiod_dly_pkg::*;
#(
  parameter int TAP_W      = 8,
  parameter int TAP_MAX    = 255,
  parameter int SETTLE_CYC = 4
) (
  input  logic             SCLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [TAP_W-1:0] CMD_COUNT,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] TAP_VAL,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_DIR,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_LOAD,
  output logic             BIT_SLIP,
  output state_t           DBG_STATE
);

  localparam int CNT_W = settle_cnt_w(SETTLE_CYC);

  // Handshake: a command is taken on a rising SCLK edge where CMD_VALID and
  // CMD_READY are both high; CMD_READY is high only in IDLE, and CMD_VALID
  // at any other time is dropped, not queued.

  state_t             state;
  op_t                op_q;
  logic [TAP_W-1:0]   steps_left;
  logic [CNT_W-1:0]   settle_cnt;
  logic               oor_s;

  logic               accept;
  op_t                cur_op;
  logic               sat;
  logic               iss_move;
  logic               iss_load;
  logic               iss_slip;
  logic [TAP_W-1:0]   next_tap;

`ifdef RXIOD_DLY_OOR_SYNC_EN
  if (SETTLE_CYC < 3) begin : g_settle_chk
    $error("SETTLE_CYC must be >= 3 when the OOR synchroniser is enabled");
  end

  rxiod_dly_sync u_oor_sync (
    .clk   (SCLK),
    .rst_n (RST_N),
    .d     (DELAY_LINE_OUT_OF_RANGE),
    .q     (oor_s)
  );
`else
  if (SETTLE_CYC < 1) begin : g_settle_chk
    $error("SETTLE_CYC must be >= 1");
  end

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) oor_s <= 1'b0;
    else        oor_s <= DELAY_LINE_OUT_OF_RANGE;
  end
`endif

  assign accept    = (state == S_IDLE) && CMD_VALID && CMD_READY;
  assign DBG_STATE = state;

  // Decode of the step about to be issued: the new opcode at accept,
  // otherwise the latched one at the end of a settle window.
  always_comb begin
    cur_op   = (state == S_IDLE) ? op_t'(CMD_OP) : op_q;
    sat      = 1'b0;
    iss_move = 1'b0;
    iss_load = 1'b0;
    iss_slip = 1'b0;
    next_tap = TAP_VAL;
    case (cur_op)
      OP_LOAD: begin
        iss_load = 1'b1;
        next_tap = '0;
      end
      OP_INC: begin
        sat      = (TAP_VAL == TAP_W'(TAP_MAX));
        iss_move = 1'b1;
        next_tap = TAP_VAL + TAP_W'(1);
      end
      OP_DEC: begin
        sat      = (TAP_VAL == '0);
        iss_move = 1'b1;
        next_tap = TAP_VAL - TAP_W'(1);
      end
      default: begin
        iss_slip = 1'b1;
      end
    endcase
  end

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= S_IDLE;
      op_q            <= OP_LOAD;
      steps_left      <= '0;
      settle_cnt      <= '0;
      CMD_READY       <= 1'b0;
      DONE            <= 1'b0;
      ERR             <= 1'b0;
      TAP_VAL         <= '0;
      DELAY_LINE_DIR  <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      BIT_SLIP        <= 1'b0;
    end else begin
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      BIT_SLIP        <= 1'b0;
      DONE            <= 1'b0;
      case (state)
        S_IDLE: begin
          CMD_READY <= 1'b1;
          if (accept) begin
            CMD_READY <= 1'b0;
            ERR       <= 1'b0;
            op_q      <= cur_op;
            if (cur_op == OP_INC)      DELAY_LINE_DIR <= 1'b1;
            else if (cur_op == OP_DEC) DELAY_LINE_DIR <= 1'b0;

            if (cur_op != OP_LOAD && CMD_COUNT == '0) begin
              DONE  <= 1'b1;
              state <= S_FIN;
            end else if (sat) begin
              ERR   <= 1'b1;
              DONE  <= 1'b1;
              state <= S_FIN;
            end else begin
              DELAY_LINE_MOVE <= iss_move;
              DELAY_LINE_LOAD <= iss_load;
              BIT_SLIP        <= iss_slip;
              TAP_VAL         <= next_tap;
              steps_left      <= (cur_op == OP_LOAD) ? '0 : CMD_COUNT - TAP_W'(1);
              state           <= S_PULSE;
            end
          end
        end

        S_PULSE: begin
          settle_cnt <= CNT_W'(SETTLE_CYC - 1);
          state      <= S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else if (oor_s) begin
            // Delay line reports out of range: drop whatever steps remain.
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= S_FIN;
          end else if (steps_left == '0) begin
            DONE  <= 1'b1;
            state <= S_FIN;
          end else if (sat) begin
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= S_FIN;
          end else begin
            DELAY_LINE_MOVE <= iss_move;
            DELAY_LINE_LOAD <= iss_load;
            BIT_SLIP        <= iss_slip;
            TAP_VAL         <= next_tap;
            steps_left      <= steps_left - TAP_W'(1);
            state           <= S_PULSE;
          end
        end

        S_FIN: begin
          CMD_READY <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rxiod_clkdiv_delay_ctrl.sv
// Scoreboard bench for rxiod_clkdiv_delay_ctrl with SETTLE_CYC=4 and hand-computed pulse timing.
module tb_rxiod_clkdiv_delay_ctrl;
  import rxiod_dly_pkg::*;

  localparam int TAP_W = 8;
  localparam int EW    = 44;
  localparam logic [1:0] K_MOVE = 2'd0;
  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_SLIP = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  logic             SCLK;
  logic             RST_N;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [TAP_W-1:0] CMD_COUNT;
  logic             DONE;
  logic             ERR;
  logic [TAP_W-1:0] TAP_VAL;
  logic             DELAY_LINE_OUT_OF_RANGE;
  logic             DELAY_LINE_DIR;
  logic             DELAY_LINE_MOVE;
  logic             DELAY_LINE_LOAD;
  logic             BIT_SLIP;
  state_t           DBG_STATE;

  rxiod_clkdiv_delay_ctrl #(
    .TAP_W      (TAP_W),
    .TAP_MAX    (255),
    .SETTLE_CYC (4)
  ) dut (
    .SCLK                    (SCLK),
    .RST_N                   (RST_N),
    .CMD_VALID               (CMD_VALID),
    .CMD_READY               (CMD_READY),
    .CMD_OP                  (CMD_OP),
    .CMD_COUNT               (CMD_COUNT),
    .DONE                    (DONE),
    .ERR                     (ERR),
    .TAP_VAL                 (TAP_VAL),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_DIR          (DELAY_LINE_DIR),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .BIT_SLIP                (BIT_SLIP),
    .DBG_STATE               (DBG_STATE)
  );

  // clock / reset
  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int cyc = 0;
  always @(posedge SCLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int c0       = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input int at,
                                       input logic [7:0] tap, input logic err,
                                       input logic dir);
    return {kind, at[31:0], tap, err, dir};
  endfunction

  // expected event at cycle offset 'off' relative to the accept cycle c0
  task automatic push(input logic [1:0] kind, input int off, input logic [7:0] tap,
                      input logic err, input logic dir);
    exp_q.push_back(ev(kind, c0 + off, tap, err, dir));
  endtask

  // scoreboard monitor
  always @(negedge SCLK) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    if (RST_N) begin
      if (DELAY_LINE_MOVE || DELAY_LINE_LOAD || BIT_SLIP) begin
        check("pulse_excl", 64'($countones({DELAY_LINE_MOVE, DELAY_LINE_LOAD, BIT_SLIP})), 64'd1);
        if (DELAY_LINE_MOVE)      obs = ev(K_MOVE, cyc, TAP_VAL, ERR, DELAY_LINE_DIR);
        else if (DELAY_LINE_LOAD) obs = ev(K_LOAD, cyc, TAP_VAL, ERR, DELAY_LINE_DIR);
        else                      obs = ev(K_SLIP, cyc, TAP_VAL, ERR, DELAY_LINE_DIR);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse act=%0h exp=none", obs);
        end else begin
          e = exp_q.pop_front();
          check("pulse_event", 64'(obs), 64'(e));
        end
      end
      if (DONE) begin
        obs = ev(K_DONE, cyc, TAP_VAL, ERR, DELAY_LINE_DIR);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done act=%0h exp=none", obs);
        end else begin
          e = exp_q.pop_front();
          check("done_event", 64'(obs), 64'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic start_cmd(input op_t op, input int count);
    int n;
    n = 0;
    @(negedge SCLK);
    while (!CMD_READY && n < 50) begin
      @(negedge SCLK);
      n++;
    end
    check("ready_before_cmd", 64'(CMD_READY), 64'd1);
    c0        = cyc;
    CMD_OP    = op;
    CMD_COUNT = count[TAP_W-1:0];
    CMD_VALID = 1'b1;
  endtask

  task automatic end_cmd();
    @(negedge SCLK);
    CMD_VALID = 1'b0;
    CMD_COUNT = '0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge SCLK);
      if (CMD_READY && exp_q.size() == 0) break;
    end
    check("idle_within_budget", 64'(i < budget), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 64'(CMD_READY), 64'd0);
    check("rst_done",  64'(DONE), 64'd0);
    check("rst_err",   64'(ERR), 64'd0);
    check("rst_tap",   64'(TAP_VAL), 64'd0);
    check("rst_pulses", 64'({DELAY_LINE_DIR, DELAY_LINE_MOVE, DELAY_LINE_LOAD, BIT_SLIP}), 64'd0);
    check("rst_state", 64'(DBG_STATE), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N                   = 1'b0;
    CMD_VALID               = 1'b0;
    CMD_OP                  = OP_LOAD;
    CMD_COUNT               = '0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;

    repeat (3) @(negedge SCLK);
    check_reset_outputs();
    RST_N = 1'b1;
    #1 check("ready_at_release", 64'(CMD_READY), 64'd0);
    @(negedge SCLK);
    check("ready_after_release", 64'(CMD_READY), 64'd1);

    // INC 3 from tap 0
    start_cmd(OP_INC, 3);
    push(K_MOVE, 1, 8'd1, 1'b0, 1'b1);
    push(K_MOVE, 6, 8'd2, 1'b0, 1'b1);
    push(K_MOVE, 11, 8'd3, 1'b0, 1'b1);
    push(K_DONE, 16, 8'd3, 1'b0, 1'b1);
    end_cmd();
    wait_idle(60);
    check("inc3_tap", 64'(TAP_VAL), 64'd3);
    check("inc3_err", 64'(ERR), 64'd0);

    // INC 251 walks the tap to 254
    start_cmd(OP_INC, 251);
    for (int i = 0; i < 251; i++) push(K_MOVE, 1 + 5 * i, 8'(4 + i), 1'b0, 1'b1);
    push(K_DONE, 1256, 8'd254, 1'b0, 1'b1);
    end_cmd();
    wait_idle(1400);
    check("inc251_tap", 64'(TAP_VAL), 64'd254);

    // INC 3 at 254: one move, then saturates
    start_cmd(OP_INC, 3);
    push(K_MOVE, 1, 8'd255, 1'b0, 1'b1);
    push(K_DONE, 6, 8'd255, 1'b1, 1'b1);
    end_cmd();
    wait_idle(60);
    check("sat_tap_nowrap", 64'(TAP_VAL), 64'd255);
    check("sat_err_sticky", 64'(ERR), 64'd1);

    // INC at TAP_MAX: no pulse at all
    start_cmd(OP_INC, 1);
    push(K_DONE, 1, 8'd255, 1'b1, 1'b1);
    end_cmd();
    wait_idle(20);

    // DEC 5 with out-of-range raised after the second move
    start_cmd(OP_DEC, 5);
    push(K_MOVE, 1, 8'd254, 1'b0, 1'b0);
    push(K_MOVE, 6, 8'd253, 1'b0, 1'b0);
    push(K_DONE, 11, 8'd253, 1'b1, 1'b0);
    end_cmd();
    check("err_cleared_on_accept", 64'(ERR), 64'd0);
    repeat (6) @(negedge SCLK);
    DELAY_LINE_OUT_OF_RANGE = 1'b1;
    wait_idle(60);
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    check("oor_tap", 64'(TAP_VAL), 64'd253);
    check("oor_err", 64'(ERR), 64'd1);

    // DEC count 0: done in cycle 1, no pulse
    start_cmd(OP_DEC, 0);
    push(K_DONE, 1, 8'd253, 1'b0, 1'b0);
    end_cmd();
    wait_idle(20);

    // SLIP 2 then LOAD
    start_cmd(OP_SLIP, 2);
    push(K_SLIP, 1, 8'd253, 1'b0, 1'b0);
    push(K_SLIP, 6, 8'd253, 1'b0, 1'b0);
    push(K_DONE, 11, 8'd253, 1'b0, 1'b0);
    end_cmd();
    wait_idle(40);
    check("slip_tap", 64'(TAP_VAL), 64'd253);

    start_cmd(OP_LOAD, 7);
    push(K_LOAD, 1, 8'd0, 1'b0, 1'b0);
    push(K_DONE, 6, 8'd0, 1'b0, 1'b0);
    end_cmd();
    wait_idle(30);
    check("load_tap", 64'(TAP_VAL), 64'd0);

    // DEC at tap 0 saturates immediately
    start_cmd(OP_DEC, 2);
    push(K_DONE, 1, 8'd0, 1'b1, 1'b0);
    end_cmd();
    wait_idle(20);
    check("dec_sat_tap", 64'(TAP_VAL), 64'd0);

    // reset in cycle 3 of INC 4
    start_cmd(OP_INC, 4);
    push(K_MOVE, 1, 8'd1, 1'b0, 1'b1);
    end_cmd();
    repeat (2) @(negedge SCLK);
    RST_N = 1'b0;
    #1;
    check_reset_outputs();
    check("abort_queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge SCLK);
    check_reset_outputs();
    RST_N = 1'b1;
    @(negedge SCLK);
    check("ready_after_abort", 64'(CMD_READY), 64'd1);
    repeat (30) @(negedge SCLK);
    check("abort_tap", 64'(TAP_VAL), 64'd0);

    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
